// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/result handshake bundle for the iterative divider
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             div_valid;
  logic             div_ready;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output div_valid, div_signed, dividend, divisor, cancel, res_ready,
    input  div_ready, res_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  div_valid, div_signed, dividend, divisor, cancel, res_ready,
    output div_ready, res_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - radix-2 restoring DIV/DIVU unit, one quotient bit per cycle
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          resetn,
  iter_divider_if.slave dif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Partial remainder is kept at WIDTH bits: after every restore step it is
  // strictly below the divisor magnitude, so its top (WIDTH+1)th bit is always
  // zero. The shift-and-trial itself is done at WIDTH+1 bits.
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dq;       // dividend magnitude, shifted out while quotient shifts in
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             dz_reg;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;

  assign accept    = (state == S_IDLE) && dif.div_valid && !dif.cancel;
  assign last_iter = (count == LAST);
  assign shifted   = {prem, dq[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs};

  assign abs_dividend = (dif.div_signed && dif.dividend[WIDTH-1]) ? (~dif.dividend + 1'b1)
                                                                  : dif.dividend;
  assign abs_divisor  = (dif.div_signed && dif.divisor[WIDTH-1])  ? (~dif.divisor + 1'b1)
                                                                  : dif.divisor;

  assign dif.div_ready   = (state == S_IDLE);
  assign dif.busy        = (state != S_IDLE);
  assign dif.res_valid   = (state == S_DONE);
  assign dif.quotient    = q_reg;
  assign dif.remainder   = r_reg;
  assign dif.div_by_zero = dz_reg;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: cancel overrides everything, including a result handshake
  always_comb begin
    state_nxt = state;
    if (dif.cancel) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (dif.div_valid) state_nxt = S_CALC;
        S_CALC:  if (last_iter)     state_nxt = S_FIX;
        S_FIX:                      state_nxt = S_DONE;
        S_DONE:  if (dif.res_ready) state_nxt = S_IDLE;
        default:                    state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand capture and the shift/subtract iteration
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prem   <= '0;
      dq     <= '0;
      dvs    <= '0;
      count  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (accept) begin
      prem   <= '0;
      dq     <= abs_dividend;
      dvs    <= abs_divisor;
      count  <= '0;
      sign_q <= dif.div_signed & (dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1]);
      sign_r <= dif.div_signed & dif.dividend[WIDTH-1];
    end else if (state == S_CALC) begin
      prem  <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      dq    <= {dq[WIDTH-2:0], ~trial[WIDTH]};
      count <= count + 1'b1;
    end
  end

  // Sign fix-up into the result registers; a cancel leaves quotient/remainder stale
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_reg  <= '0;
      r_reg  <= '0;
      dz_reg <= 1'b0;
    end else if (dif.cancel) begin
      dz_reg <= 1'b0;
    end else if (state == S_FIX) begin
      q_reg  <= sign_q ? (~dq + 1'b1) : dq;
      r_reg  <= sign_r ? (~prem + 1'b1) : prem;
      dz_reg <= (dvs == '0);
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - directed self-checking bench for iter_divider
module tb_iter_divider;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  iter_divider_if #(.WIDTH(32)) dif ();

  iter_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .dif    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the result has been consumed.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!dif.div_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, " ready"}, {31'd0, dif.div_ready}, 32'd1);
    dif.div_valid  = 1'b1;
    dif.div_signed = sgn;
    dif.dividend   = a;
    dif.divisor    = b;
    dif.res_ready  = (hold == 0);
    @(posedge clk);
    #1;
    dif.div_valid  = 1'b0;
    dif.dividend   = ~a;
    dif.divisor    = 32'h0;
    dif.div_signed = ~sgn;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (dif.res_valid) break;
    end
    check_val({tag, " latency"}, lat, 32'd33);
    check_val({tag, " q"}, dif.quotient, eq);
    check_val({tag, " r"}, dif.remainder, er);
    check_val({tag, " dz"}, {31'd0, dif.div_by_zero}, {31'd0, edz});
    for (int i = 0; i < hold; i++) begin
      dif.dividend   = $urandom;
      dif.divisor    = $urandom;
      dif.div_signed = ~dif.div_signed;
      @(negedge clk);
      check_val({tag, " hold q"}, dif.quotient, eq);
      check_val({tag, " hold r"}, dif.remainder, er);
      check_val({tag, " hold valid"}, {31'd0, dif.res_valid}, 32'd1);
    end
    dif.res_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.res_ready = 1'b0;
    @(negedge clk);
    check_val({tag, " valid low"}, {31'd0, dif.res_valid}, 32'd0);
    check_val({tag, " ready back"}, {31'd0, dif.div_ready}, 32'd1);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    resetn         = 1'b0;
    dif.div_valid  = 1'b0;
    dif.div_signed = 1'b0;
    dif.dividend   = '0;
    dif.divisor    = '0;
    dif.cancel     = 1'b0;
    dif.res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_val("rst valid", {31'd0, dif.res_valid}, 32'd0);
    check_val("rst q", dif.quotient, 32'd0);
    check_val("rst r", dif.remainder, 32'd0);
    check_val("rst dz", {31'd0, dif.div_by_zero}, 32'd0);
    check_val("rst busy", {31'd0, dif.busy}, 32'd0);
    check_val("rst ready", {31'd0, dif.div_ready}, 32'd1);

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);
    run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0);
    run_div("divu ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0);
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, 1'b1, 0);

    // cancel together with a request in IDLE: nothing is accepted
    dif.div_valid = 1'b1;
    dif.dividend  = 32'd100;
    dif.divisor   = 32'd7;
    dif.cancel    = 1'b1;
    @(posedge clk);
    #1;
    dif.div_valid = 1'b0;
    dif.cancel    = 1'b0;
    @(negedge clk);
    check_val("idle cancel busy", {31'd0, dif.busy}, 32'd0);
    check_val("idle cancel dz", {31'd0, dif.div_by_zero}, 32'd0);

    // cancel on the 10th CALC cycle
    dif.div_valid  = 1'b1;
    dif.div_signed = 1'b0;
    dif.dividend   = 32'd100;
    dif.divisor    = 32'd7;
    @(posedge clk);
    #1;
    dif.div_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_val("calc busy", {31'd0, dif.busy}, 32'd1);
    dif.cancel = 1'b1;
    @(posedge clk);
    #1;
    dif.cancel = 1'b0;
    @(negedge clk);
    check_val("cancel ready", {31'd0, dif.div_ready}, 32'd1);
    check_val("cancel valid", {31'd0, dif.res_valid}, 32'd0);
    check_val("cancel stale q", dif.quotient, 32'd1);
    run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    run_div("hold 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 5);

    // asynchronous reset in the middle of CALC
    dif.div_valid  = 1'b1;
    dif.div_signed = 1'b0;
    dif.dividend   = 32'd100;
    dif.divisor    = 32'd7;
    @(posedge clk);
    #1;
    dif.div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_val("arst q", dif.quotient, 32'd0);
    check_val("arst r", dif.remainder, 32'd0);
    check_val("arst busy", {31'd0, dif.busy}, 32'd0);
    check_val("arst valid", {31'd0, dif.res_valid}, 32'd0);
    check_val("arst dz", {31'd0, dif.div_by_zero}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_val("arst ready", {31'd0, dif.div_ready}, 32'd1);
    run_div("post rst 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
